// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: load/store bus for data_mem_lsu; store_count exists only with DATA_MEM_STORE_CNT_EN
interface data_mem_lsu_if #(parameter int ADDRESS_WIDTH = 32);
  logic                     write_en;
  logic                     clear_req;
  logic [2:0]               funct3;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [31:0]              data_in;
  logic [31:0]              data_out;
  logic                     fault;
  logic                     busy;
`ifdef DATA_MEM_STORE_CNT_EN
  logic [31:0]              store_count;
  modport master(output write_en, clear_req, funct3, addr, data_in, input data_out, fault, busy, store_count);
  modport slave(input write_en, clear_req, funct3, addr, data_in, output data_out, fault, busy, store_count);
`else
  modport master(output write_en, clear_req, funct3, addr, data_in, input data_out, fault, busy);
  modport slave(input write_en, clear_req, funct3, addr, data_in, output data_out, fault, busy);
`endif
endinterface

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte/half/word data memory with sweep clear; DATA_MEM_STORE_CNT_EN adds a saturating store counter
module data_mem_lsu #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input logic clk,
  input logic clr,
  data_mem_lsu_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_clr_ptr, w_idx;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] w_word, w_wdata, w_load;
  logic [15:0] w_half;
  logic [7:0] w_byte;
  logic [3:0] w_be;
  logic [1:0] w_off;
  logic w_busy, w_fault, w_store;
  assign w_idx = bus.addr[IW+1:2];
  assign w_off = bus.addr[1:0];
  assign w_busy = r_state == CLEAR;
  assign w_fault = ((bus.funct3[1:0] == 2'b01) & bus.addr[0])
                 | ((bus.funct3 == 3'b010) & (w_off != 2'b00))
                 | (bus.funct3 inside {3'b011, 3'b110, 3'b111})
                 | (bus.funct3[2] & bus.write_en);
  assign w_store = bus.write_en & ~w_fault & ~w_busy;
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = bus.addr[1] ? w_word[31:16] : w_word[15:0];
  // funct3[2] selects zero extension for BU/HU
  assign w_load = bus.funct3[1] ? w_word
                : bus.funct3[0] ? {{16{~bus.funct3[2] & w_half[15]}}, w_half}
                : {{24{~bus.funct3[2] & w_byte[7]}}, w_byte};
  assign w_be = bus.funct3[1] ? 4'hF : bus.funct3[0] ? (bus.addr[1] ? 4'hC : 4'h3) : 4'b0001 << w_off;
  assign w_wdata = bus.funct3[1] ? bus.data_in : bus.funct3[0] ? {2{bus.data_in[15:0]}} : {4{bus.data_in[7:0]}};
  assign bus.data_out = (w_fault | w_busy) ? 32'd0 : w_load;
  assign bus.fault = w_fault;
  assign bus.busy = w_busy;
  always_comb begin
    w_next = r_state;
    if (r_state == CLEAR) w_next = (r_clr_ptr == IW'(DEPTH - 1)) ? IDLE : CLEAR;
    else w_next = bus.clear_req ? CLEAR : IDLE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_next;
      r_clr_ptr <= w_busy ? r_clr_ptr + IW'(1) : '0;
    end
  end
  // no reset on the array so it can map to block RAM; the sweep zeroes it
  always_ff @(posedge clk) begin
    if (w_busy) r_mem[r_clr_ptr] <= '0;
    else if (w_store)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
`ifdef DATA_MEM_STORE_CNT_EN
  logic [31:0] r_store_count;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_store_count <= '0;
    else if (w_store && r_store_count != 32'hFFFF_FFFF) r_store_count <= r_store_count + 32'd1;
  end
  assign bus.store_count = r_store_count;
`endif
endmodule
